xbus_tx: RTL and testbench
==========================

XBUS_TX -- requirements
Module: xbus_tx

Interface
REQ-001 Parameter DATA_W, default 11, width of one XBus/simple-I/O word (two's complement).
REQ-002 Parameter MAX_MAG, default 999, largest legal magnitude of a transmitted word.
REQ-003 Parameter WAIT_W, default 8, width of the wait counter.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 posedge_big_clk  input  1  one-clk-wide pulse marking each big (time-slice) clock boundary.
REQ-007 wr_req  input  1  core requests an XBus write; held high until wr_stall is low.
REQ-008 wr_data  input  DATA_W  signed word to write; sampled with wr_req.
REQ-009 wr_stall  output  1  core must hold its current instruction while high.
REQ-010 bus_valid  output  1  a word is offered to the reader.
REQ-011 bus_data  output  DATA_W  offered word; stable while bus_valid is high.
REQ-012 bus_ready  input  1  reader accepts the offered word this cycle.
REQ-013 wait_slices  output  WAIT_W  number of big-clock boundaries elapsed while the current word was offered.

Function
REQ-014 The block SHALL implement the three states IDLE, OFFER and DONE.
REQ-015 IDLE with wr_req=1: capture the clamped wr_data into bus_data, clear wait_slices, go to OFFER.
REQ-016 Clamping: values above +MAX_MAG become +MAX_MAG; values below -MAX_MAG become -MAX_MAG; all others pass unchanged.
REQ-017 bus_valid SHALL be high exactly when the state is OFFER, with 1-cycle latency from the capturing edge.
REQ-018 OFFER with bus_ready=1 (handshake): go to DONE; bus_valid drops on the next cycle.
REQ-019 OFFER with bus_ready=0: remain in OFFER indefinitely (blocking write), holding bus_data constant.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 wr_stall SHALL be combinational and equal to wr_req AND (state != DONE), so the core sees stall low only in the DONE cycle.
REQ-022 A wr_req still high in the cycle after DONE (IDLE) SHALL be treated as a new write.
REQ-023 bus_ready while in IDLE or DONE SHALL be ignored.
REQ-024 wait_slices SHALL increment once per cycle in OFFER with posedge_big_clk=1, and SHALL saturate at all-ones.
REQ-025 wait_slices SHALL hold its value through DONE and IDLE until the next capture.
REQ-026 If posedge_big_clk and a handshake occur in the same cycle, the increment SHALL still apply.
REQ-027 Deasserting wr_req during OFFER SHALL NOT withdraw the offer; the word stays offered until accepted.

Reset
REQ-028 While reset_n=0 the block SHALL hold: state=IDLE, bus_valid=0, bus_data=0, wait_slices=0.
REQ-029 Reset asserted mid-OFFER SHALL drop bus_valid immediately (asynchronously) and discard the offered word.
REQ-030 The first capture SHALL be possible on the first rising clk edge after reset_n goes high.

Structure
REQ-031 The state enum, DATA_W and MAX_MAG defaults SHALL live in shared package xbus_pkg, reused by the future xbus_rx.
REQ-032 The clamp SHALL be a separate combinational sub-module xbus_clamp, also shared with xbus_rx.
REQ-033 Only the state, bus_data and wait_slices SHALL be registered; wr_stall and bus_valid decode from the state.

Verification
REQ-034 Write 37 with bus_ready tied high -> bus_valid high with bus_data=37 for one cycle, wr_stall low in the following DONE cycle, wait_slices=0.
REQ-035 Write 1500, then write -2000 -> bus_data=999, then bus_data=-999 (11'h419).
REQ-036 Write 5 with bus_ready low across 3 big-clock pulses, then bus_ready=1 -> bus_data held at 5 throughout, wait_slices=3, wr_stall high until DONE.
REQ-037 Hold the offer across 300 big-clock pulses -> wait_slices saturates at 255.
REQ-038 Assert reset_n=0 mid-OFFER with bus_data=42 -> bus_valid=0 with no clk edge, bus_data=0; after release, write 7 -> normal handshake.
REQ-039 Back-to-back writes 1 and 2, with wr_req held high and bus_ready high -> two handshakes one IDLE cycle apart, values in order.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared XBus definitions: transmitter/receiver state encoding and word-format defaults.
package xbus_pkg;

  localparam int XBUS_DATA_W  = 11;
  localparam int XBUS_MAX_MAG = 999;
  localparam int XBUS_WAIT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_DONE  = 2'd2
  } xbus_state_e;

endpackage

// File: rtl/xbus_clamp.sv
// Combinational symmetric saturation of a two's-complement word to +/-MAX_MAG.
module xbus_clamp #(
  parameter int DATA_W  = 11,
  parameter int MAX_MAG = 999
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam logic signed [DATA_W-1:0] LP_POS = DATA_W'(MAX_MAG);
  localparam logic signed [DATA_W-1:0] LP_NEG = DATA_W'(-MAX_MAG);

  logic signed [DATA_W-1:0] w_in;
  assign w_in = $signed(i_data);

  always_comb begin
    o_data = i_data;
    if (w_in > LP_POS)      o_data = LP_POS;
    else if (w_in < LP_NEG) o_data = LP_NEG;
  end

endmodule

// File: rtl/xbus_tx.sv
// XBus blocking-write transmitter: offers one clamped word until the reader accepts it,
// stalling the core and counting big-clock boundaries spent waiting.
module xbus_tx
  import xbus_pkg::*;
#(
  parameter int DATA_W  = XBUS_DATA_W,
  parameter int MAX_MAG = XBUS_MAX_MAG,
  parameter int WAIT_W  = XBUS_WAIT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              posedge_big_clk,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_stall,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_ready,
  output logic [WAIT_W-1:0] wait_slices
);

  xbus_state_e       r_state, w_next;
  logic [DATA_W-1:0] r_data;
  logic [WAIT_W-1:0] r_wait;
  logic [DATA_W-1:0] w_clamped;
  logic              w_capture;

  xbus_clamp #(.DATA_W(DATA_W), .MAX_MAG(MAX_MAG)) u_clamp (
    .i_data (wr_data),
    .o_data (w_clamped)
  );

  assign w_capture = (r_state == ST_IDLE) && wr_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (wr_req)    w_next = ST_OFFER;
      ST_OFFER: if (bus_ready) w_next = ST_DONE;
      ST_DONE:                 w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  // Stall drops only in DONE so the core retires the write exactly once.
  always_comb begin
    bus_valid = (r_state == ST_OFFER);
    wr_stall  = wr_req && (r_state != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_wait <= '0;
    end else if (w_capture) begin
      r_data <= w_clamped;
      r_wait <= '0;
    end else if ((r_state == ST_OFFER) && posedge_big_clk && !(&r_wait)) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign bus_data    = r_data;
  assign wait_slices = r_wait;

endmodule

// File: tb/tb_xbus_tx.sv
// Directed bench for xbus_tx: table of write transactions plus hand-built corner sequences.
module tb_xbus_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        posedge_big_clk = 1'b0;
  logic        wr_req = 1'b0;
  logic [10:0] wr_data = '0;
  logic        wr_stall;
  logic        bus_valid;
  logic signed [10:0] bus_data;
  logic        bus_ready = 1'b0;
  logic [7:0]  wait_slices;

  int total = 0;
  int bad   = 0;

  xbus_tx dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .posedge_big_clk (posedge_big_clk),
    .wr_req          (wr_req),
    .wr_data         (wr_data),
    .wr_stall        (wr_stall),
    .bus_valid       (bus_valid),
    .bus_data        (bus_data),
    .bus_ready       (bus_ready),
    .wait_slices     (wait_slices)
  );

  always #5 clk = ~clk;

  typedef struct {
    int din;
    int pulses;
    bit hs_pulse;
    int exp_data;
    int exp_wait;
    int exp_wait_post;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
  task automatic do_write(input vec_t v);
    int d;
    wr_req = 1'b1;
    d = v.din;
    wr_data = d[10:0];
    bus_ready = (v.pulses == 0) && !v.hs_pulse;
    posedge_big_clk = 1'b0;
    #1 chk("stall_idle", int'(wr_stall), 1);
    @(negedge clk);
    for (int i = 0; i < v.pulses; i++) begin
      chk("valid_hold", int'(bus_valid), 1);
      chk("data_hold", int'(bus_data), v.exp_data);
      posedge_big_clk = 1'b1;
      @(negedge clk);
      posedge_big_clk = 1'b0;
    end
    chk("valid_offer", int'(bus_valid), 1);
    chk("data_offer", int'(bus_data), v.exp_data);
    chk("wait_offer", int'(wait_slices), v.exp_wait);
    chk("stall_offer", int'(wr_stall), 1);
    bus_ready = 1'b1;
    posedge_big_clk = v.hs_pulse;
    @(negedge clk);
    posedge_big_clk = 1'b0;
    chk("valid_done", int'(bus_valid), 0);
    chk("stall_done", int'(wr_stall), 0);
    chk("wait_done", int'(wait_slices), v.exp_wait_post);
    wr_req = 1'b0;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("valid_idle", int'(bus_valid), 0);
    chk("wait_idle", int'(wait_slices), v.exp_wait_post);
    chk("data_idle", int'(bus_data), v.exp_data);
  endtask

  initial begin
    vecs[0]  = '{37,    0,   1'b0,  37,   0,   0};
    vecs[1]  = '{1023,  0,   1'b0,  999,  0,   0};
    vecs[2]  = '{-1024, 0,   1'b0, -999,  0,   0};
    vecs[3]  = '{5,     3,   1'b0,  5,    3,   3};
    vecs[4]  = '{1000,  2,   1'b1,  999,  2,   3};
    vecs[5]  = '{-1000, 1,   1'b0, -999,  1,   1};
    vecs[6]  = '{999,   0,   1'b0,  999,  0,   0};
    vecs[7]  = '{-999,  0,   1'b0, -999,  0,   0};
    vecs[8]  = '{0,     0,   1'b0,  0,    0,   0};
    vecs[9]  = '{-37,   4,   1'b1, -37,   4,   5};
    vecs[10] = '{5,     300, 1'b0,  5,    255, 255};
    vecs[11] = '{1,     0,   1'b0,  1,    0,   0};

    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(bus_valid), 0);
    chk("rst_data", int'(bus_data), 0);
    chk("rst_wait", int'(wait_slices), 0);
    chk("rst_stall", int'(wr_stall), 0);
    reset_n = 1'b1;

    foreach (vecs[i]) do_write(vecs[i]);

    // bus_ready in IDLE must not start anything
    bus_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_valid", int'(bus_valid), 0);
    end
    bus_ready = 1'b0;

    // Dropping wr_req mid-offer keeps the word on the bus
    wr_req = 1'b1; wr_data = 11'd77;
    @(negedge clk);
    wr_req = 1'b0;
    #1 chk("drop_stall", int'(wr_stall), 0);
    @(negedge clk);
    chk("drop_valid", int'(bus_valid), 1);
    chk("drop_data", int'(bus_data), 77);
    bus_ready = 1'b1;
    @(negedge clk);
    chk("drop_done_valid", int'(bus_valid), 0);
    bus_ready = 1'b0;
    @(negedge clk);

    // Async reset in the middle of an offer
    wr_req = 1'b1; wr_data = 11'd42;
    @(negedge clk);
    wr_req = 1'b0;
    posedge_big_clk = 1'b1;
    @(negedge clk);
    posedge_big_clk = 1'b0;
    chk("pre_rst_valid", int'(bus_valid), 1);
    chk("pre_rst_data", int'(bus_data), 42);
    chk("pre_rst_wait", int'(wait_slices), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus_valid), 0);
    chk("async_rst_data", int'(bus_data), 0);
    chk("async_rst_wait", int'(wait_slices), 0);
    @(negedge clk);
    chk("rst_hold_valid", int'(bus_valid), 0);
    reset_n = 1'b1;
    do_write('{7, 0, 1'b0, 7, 0, 0});

    // Back-to-back writes with wr_req and bus_ready held high
    wr_req = 1'b1; wr_data = 11'd1; bus_ready = 1'b1;
    @(negedge clk);
    chk("b2b_v1", int'(bus_valid), 1);
    chk("b2b_d1", int'(bus_data), 1);
    wr_data = 11'd2;
    @(negedge clk);
    chk("b2b_done1_valid", int'(bus_valid), 0);
    chk("b2b_done1_stall", int'(wr_stall), 0);
    @(negedge clk);
    chk("b2b_idle_valid", int'(bus_valid), 0);
    chk("b2b_idle_stall", int'(wr_stall), 1);
    @(negedge clk);
    chk("b2b_v2", int'(bus_valid), 1);
    chk("b2b_d2", int'(bus_data), 2);
    @(negedge clk);
    chk("b2b_done2_valid", int'(bus_valid), 0);
    chk("b2b_done2_stall", int'(wr_stall), 0);
    wr_req = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    chk("b2b_end_valid", int'(bus_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
